range_iter: RTL
===============

RANGE_ITER -- requirements
Module: range_iter

Interface
REQ-001 The block SHALL have parameter CHAR_BITS, default 8, meaning the width of one character.
REQ-002 The block SHALL have parameter RANGES_MAX, default 4, meaning the number of independent ranges.
REQ-003 The block SHALL have port CLK, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: the reset, which is synchronous and active-high.
REQ-005 The block SHALL have port cfg_wr_en, input, 1 bit: writes the range config entry selected by cfg_idx.
REQ-006 The block SHALL have port cfg_idx, input, clog2(RANGES_MAX) bits: the range index being written.
REQ-007 The block SHALL have port cfg_lo, input, CHAR_BITS bits: the first character of the range, inclusive.
REQ-008 The block SHALL have port cfg_hi, input, CHAR_BITS bits: the last character of the range, inclusive.
REQ-009 The block SHALL have port cfg_active, input, 1 bit: marks the range as participating.
REQ-010 The block SHALL have port start, input, 1 bit: a pulse that begins enumeration.
REQ-011 The block SHALL have port abort, input, 1 bit: a pulse that ends enumeration immediately.
REQ-012 The block SHALL have port busy, output, 1 bit: high when the state is not IDLE.
REQ-013 The block SHALL have port ranges, output, RANGES_MAX*CHAR_BITS bits: the current characters, with range i at bits [(i+1)*CHAR_BITS-1 -: CHAR_BITS].
REQ-014 The block SHALL have port ranges_active, output, RANGES_MAX bits: the latched active mask.
REQ-015 The block SHALL have port out_valid, output, 1 bit: the candidate on ranges is valid.
REQ-016 The block SHALL have port out_ready, input, 1 bit: the consumer accepts the candidate.
REQ-017 The block SHALL have port out_last, output, 1 bit: marks the final candidate of an enumeration.

Function
REQ-018 The state machine SHALL have exactly the states IDLE, RUN and FLUSH.
REQ-019 In IDLE, cfg_wr_en SHALL update the config entry at cfg_idx on the next edge; in RUN and FLUSH, cfg_wr_en SHALL be ignored.
REQ-020 If an entry has cfg_lo > cfg_hi, it SHALL enumerate only cfg_lo.
REQ-021 When start is high in IDLE, the block SHALL latch the active mask, load every active range counter with its lo value, load inactive counters with 0, and enter RUN with out_valid=1 on the next cycle.
REQ-022 In RUN, ranges, ranges_active and out_last SHALL hold stable while out_valid=1 and out_ready=0.
REQ-023 On each out_valid && out_ready, the counters SHALL advance odometer-style: range 0 is the fastest-changing, an active range at hi wraps to lo and carries into the next active range, and inactive ranges are skipped and stay 0.
REQ-024 out_last SHALL be 1 exactly when every active range equals its effective hi.
REQ-025 When the out_last candidate is accepted, the block SHALL enter FLUSH with out_valid=0, then return to IDLE on the following cycle.
REQ-026 Throughput SHALL be one candidate per cycle while out_ready=1, with no bubbles.
REQ-027 If the active mask is zero at start, the block SHALL emit exactly one candidate with ranges=0 and out_last=1.
REQ-028 If abort is high in any state, the block SHALL be in IDLE with out_valid=0 on the next cycle; abort SHALL take priority over start and over a handshake in the same cycle.
REQ-029 start SHALL be ignored outside IDLE.
REQ-030 busy SHALL be high in RUN and FLUSH.

Reset
REQ-031 While rst is high, the block SHALL set state=IDLE, out_valid=0, out_last=0, ranges=0, ranges_active=0, busy=0, and set every config entry to lo=0, hi=0, active=0.
REQ-032 rst asserted mid-enumeration SHALL discard the current candidate without completing any handshake, and rst SHALL override abort, start and cfg_wr_en.

Configuration
REQ-033 When macro RANGE_ITER_CNT_EN is defined, the block SHALL add output cand_cnt, 32 bits, which is cleared on start and on rst, increments on each accepted candidate, wraps modulo 2^32, and holds its value in IDLE.
REQ-034 When RANGE_ITER_CNT_EN is not defined, the port cand_cnt and its counter SHALL be absent, and all other behaviour SHALL be unchanged.

Verification (CHAR_BITS=8, RANGES_MAX=2)
REQ-035 The bench SHALL check that with range0 = 'a'..'c', range1 = '0'..'1', both active, and out_ready=1, the block emits 6 candidates, first a0 then b0, c0, a1, b1, c1, with out_last only on c1, returns to IDLE 2 cycles later, and cand_cnt=6 when the macro is defined.
REQ-036 The bench SHALL check that with only range1 = 'x'..'y' active, the block emits 2 candidates, range0 stays 0x00, and ranges_active=2'b10.
REQ-037 The bench SHALL check that with out_ready toggling 1,0,0,1 on the scenario of REQ-035, ranges holds during the low cycles and no candidate is skipped or duplicated.
REQ-038 The bench SHALL check that an active mask of 0 at start produces a single candidate with ranges=0x0000 and out_last=1.
REQ-039 The bench SHALL check that abort asserted on the 3rd candidate gives out_valid=0 and busy=0 the next cycle, and that a following start restarts from a0.
REQ-040 The bench SHALL check that rst asserted during RUN clears all outputs, and that a start right after rst emits one candidate with out_last=1 because all config entries are inactive.

Source files
------------

// File: rtl/range_iter_if.sv
// Bundle of config, control and candidate-stream signals for range_iter.
// cand_cnt is present only when RANGE_ITER_CNT_EN is defined.
interface range_iter_if #(
    parameter int unsigned CHAR_BITS  = 8,
    parameter int unsigned RANGES_MAX = 4
) ();
    localparam int unsigned IDX_W = (RANGES_MAX > 1) ? $clog2(RANGES_MAX) : 1;

    logic                             cfg_wr_en;
    logic [IDX_W-1:0]                 cfg_idx;
    logic [CHAR_BITS-1:0]             cfg_lo;
    logic [CHAR_BITS-1:0]             cfg_hi;
    logic                             cfg_active;
    logic                             start;
    logic                             abort;
    logic                             busy;
    logic [RANGES_MAX*CHAR_BITS-1:0]  ranges;
    logic [RANGES_MAX-1:0]            ranges_active;
    logic                             out_valid;
    logic                             out_ready;
    logic                             out_last;
`ifdef RANGE_ITER_CNT_EN
    logic [31:0]                      cand_cnt;
`endif

    // master: the enumerator itself
    modport master (
        input  cfg_wr_en, cfg_idx, cfg_lo, cfg_hi, cfg_active, start, abort, out_ready,
        output busy, ranges, ranges_active, out_valid, out_last
`ifdef RANGE_ITER_CNT_EN
        , output cand_cnt
`endif
    );

    // slave: configuring agent and candidate consumer
    modport slave (
        output cfg_wr_en, cfg_idx, cfg_lo, cfg_hi, cfg_active, start, abort, out_ready,
        input  busy, ranges, ranges_active, out_valid, out_last
`ifdef RANGE_ITER_CNT_EN
        , input cand_cnt
`endif
    );
endinterface

// File: rtl/range_iter.sv
// Odometer-style enumerator over up to RANGES_MAX character ranges.
// Define RANGE_ITER_CNT_EN to add the 32-bit accepted-candidate counter cand_cnt.
module range_iter #(
    parameter int unsigned CHAR_BITS  = 8,
    parameter int unsigned RANGES_MAX = 4
) (
    input logic         CLK,
    input logic         rst,
    range_iter_if.master bus
);
    localparam int unsigned IDX_W = (RANGES_MAX > 1) ? $clog2(RANGES_MAX) : 1;
    localparam int unsigned VEC_W = RANGES_MAX * CHAR_BITS;

    typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

    state_t                 state_q, state_d;
    logic [CHAR_BITS-1:0]   cfg_lo_q [RANGES_MAX];
    logic [CHAR_BITS-1:0]   cfg_hi_q [RANGES_MAX];
    logic [RANGES_MAX-1:0]  cfg_act_q;
    logic [CHAR_BITS-1:0]   run_lo_q [RANGES_MAX];
    logic [CHAR_BITS-1:0]   run_hi_q [RANGES_MAX];
    logic [VEC_W-1:0]       ranges_q, ranges_d, adv_vec, start_vec;
    logic [RANGES_MAX-1:0]  act_q, act_d;
    logic                   valid_q, valid_d, last_q, last_d, busy_q, busy_d;
    logic                   adv_last, start_last, load_run;

    // Next candidate: range 0 fastest, inactive ranges skipped and held at zero
    always_comb begin : advance
        logic                 carry;
        logic [CHAR_BITS-1:0] cur;
        carry    = 1'b1;
        cur      = '0;
        adv_vec  = '0;
        adv_last = 1'b1;
        for (int unsigned i = 0; i < RANGES_MAX; i++) begin
            cur = ranges_q[i*CHAR_BITS +: CHAR_BITS];
            if (act_q[i]) begin
                if (carry && (cur == run_hi_q[i])) begin
                    adv_vec[i*CHAR_BITS +: CHAR_BITS] = run_lo_q[i];
                end else if (carry) begin
                    adv_vec[i*CHAR_BITS +: CHAR_BITS] = CHAR_BITS'(cur + 1'b1);
                    carry = 1'b0;
                end else begin
                    adv_vec[i*CHAR_BITS +: CHAR_BITS] = cur;
                end
                if (adv_vec[i*CHAR_BITS +: CHAR_BITS] != run_hi_q[i]) adv_last = 1'b0;
            end
        end
    end

    // First candidate taken straight from config; lo >= hi means a single value
    always_comb begin : first_cand
        start_vec  = '0;
        start_last = 1'b1;
        for (int unsigned i = 0; i < RANGES_MAX; i++) begin
            if (cfg_act_q[i]) begin
                start_vec[i*CHAR_BITS +: CHAR_BITS] = cfg_lo_q[i];
                if (cfg_hi_q[i] > cfg_lo_q[i]) start_last = 1'b0;
            end
        end
    end

    // Next-state and registered-output values
    always_comb begin : fsm_next
        state_d  = state_q;
        ranges_d = ranges_q;
        act_d    = act_q;
        valid_d  = valid_q;
        last_d   = last_q;
        load_run = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d  = RUN;
                    ranges_d = start_vec;
                    act_d    = cfg_act_q;
                    valid_d  = 1'b1;
                    last_d   = start_last;
                    load_run = 1'b1;
                end
            end
            RUN: begin
                if (valid_q && bus.out_ready) begin
                    if (last_q) begin
                        state_d = FLUSH;
                        valid_d = 1'b0;
                        last_d  = 1'b0;
                    end else begin
                        ranges_d = adv_vec;
                        last_d   = adv_last;
                    end
                end
            end
            FLUSH: state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // abort wins over start and over a handshake in the same cycle
        if (bus.abort) begin
            state_d  = IDLE;
            ranges_d = ranges_q;
            act_d    = act_q;
            valid_d  = 1'b0;
            last_d   = 1'b0;
            load_run = 1'b0;
        end
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge CLK) begin
        if (rst) begin
            state_q  <= IDLE;
            ranges_q <= '0;
            act_q    <= '0;
            valid_q  <= 1'b0;
            last_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            ranges_q <= ranges_d;
            act_q    <= act_d;
            valid_q  <= valid_d;
            last_q   <= last_d;
            busy_q   <= busy_d;
        end
    end

    // Config table plus a run-time copy of lo/effective-hi captured at start
    always_ff @(posedge CLK) begin
        if (rst) begin
            cfg_act_q <= '0;
            for (int unsigned i = 0; i < RANGES_MAX; i++) begin
                cfg_lo_q[i] <= '0;
                cfg_hi_q[i] <= '0;
                run_lo_q[i] <= '0;
                run_hi_q[i] <= '0;
            end
        end else begin
            if ((state_q == IDLE) && bus.cfg_wr_en) begin
                for (int unsigned i = 0; i < RANGES_MAX; i++) begin
                    if (bus.cfg_idx == IDX_W'(i)) begin
                        cfg_lo_q[i]  <= bus.cfg_lo;
                        cfg_hi_q[i]  <= bus.cfg_hi;
                        cfg_act_q[i] <= bus.cfg_active;
                    end
                end
            end
            if (load_run) begin
                for (int unsigned i = 0; i < RANGES_MAX; i++) begin
                    run_lo_q[i] <= cfg_lo_q[i];
                    run_hi_q[i] <= (cfg_hi_q[i] < cfg_lo_q[i]) ? cfg_lo_q[i] : cfg_hi_q[i];
                end
            end
        end
    end

`ifdef RANGE_ITER_CNT_EN
    logic [31:0] cnt_q;
    logic        cnt_inc;

    assign cnt_inc = (state_q == RUN) && valid_q && bus.out_ready && !bus.abort;

    always_ff @(posedge CLK) begin
        if (rst)           cnt_q <= '0;
        else if (load_run) cnt_q <= '0;
        else if (cnt_inc)  cnt_q <= cnt_q + 32'd1;
    end

    assign bus.cand_cnt = cnt_q;
`endif

    assign bus.busy          = busy_q;
    assign bus.ranges        = ranges_q;
    assign bus.ranges_active = act_q;
    assign bus.out_valid     = valid_q;
    assign bus.out_last      = last_q;
endmodule
